// File: rtl/core_dbus.sv
// core_dbus: bridges the core data port to the data SRAM and a small MMIO window (64-bit timer, UART TX).
// Define DBUS_UART_EN to build the 8N1 UART transmitter; without it uart_txd idles high and the UART registers read 0.
module core_dbus #(
    parameter logic [15:0] MMIO_BASE = 16'hFF00,
    parameter int unsigned BAUD_DIV  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dat_a,
    input  logic [3:0]  dat_we,
    input  logic [31:0] dat_wd,
    input  logic [3:0]  dat_re,
    output logic [31:0] dat_rd,
    output logic [15:0] ram_a,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wd,
    output logic [3:0]  ram_re,
    input  logic [31:0] ram_rd,
    output logic        tmr_irq,
    output logic        uart_txd
);

    localparam logic [5:0] OFF_MTIME_LO = 6'h00;
    localparam logic [5:0] OFF_MTIME_HI = 6'h01;
    localparam logic [5:0] OFF_CMP_LO   = 6'h02;
    localparam logic [5:0] OFF_CMP_HI   = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h05;

    logic        mmio_hit;
    logic [5:0]  word_off;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [31:0] wr_mask;

    assign mmio_hit = (dat_a[15:8] == MMIO_BASE[15:8]);
    assign word_off = dat_a[7:2];
    assign mmio_wr  = mmio_hit && (|dat_we);
    assign mmio_rd  = mmio_hit && (|dat_re);

    assign ram_a  = dat_a;
    assign ram_wd = dat_wd;
    assign ram_we = mmio_hit ? 4'b0000 : dat_we;
    assign ram_re = mmio_hit ? 4'b0000 : dat_re;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_mask
            assign wr_mask[gi*8 +: 8] = {8{dat_we[gi]}};
        end
    endgenerate

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [31:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    // ------------------------------------------------------------------
    // Machine timer
    // ------------------------------------------------------------------
    logic [63:0] mtime_reg;
    logic [63:0] mtimecmp_reg;
    logic        tmr_irq_reg;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;

    assign wr_mtime_lo = mmio_wr && (word_off == OFF_MTIME_LO);
    assign wr_mtime_hi = mmio_wr && (word_off == OFF_MTIME_HI);
    assign wr_cmp_lo   = mmio_wr && (word_off == OFF_CMP_LO);
    assign wr_cmp_hi   = mmio_wr && (word_off == OFF_CMP_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg    <= 64'h0;
            mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
            tmr_irq_reg  <= 1'b0;
        end else begin
            tmr_irq_reg <= (mtime_reg >= mtimecmp_reg);
            // A software load of either half freezes the whole counter for that cycle.
            if (wr_mtime_lo) begin
                mtime_reg[31:0] <= merge_bytes(mtime_reg[31:0], dat_wd, wr_mask);
            end else if (wr_mtime_hi) begin
                mtime_reg[63:32] <= merge_bytes(mtime_reg[63:32], dat_wd, wr_mask);
            end else begin
                mtime_reg <= mtime_reg + 64'd1;
            end
            if (wr_cmp_lo) begin
                mtimecmp_reg[31:0] <= merge_bytes(mtimecmp_reg[31:0], dat_wd, wr_mask);
            end
            if (wr_cmp_hi) begin
                mtimecmp_reg[63:32] <= merge_bytes(mtimecmp_reg[63:32], dat_wd, wr_mask);
            end
        end
    end

    assign tmr_irq = tmr_irq_reg;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    logic [31:0] status_word;

`ifdef DBUS_UART_EN
    localparam logic [5:0]  OFF_TX    = 6'h04;
    localparam int unsigned BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    uart_state_t       state_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_idx_reg;
    logic [2:0]        bit_idx_next;
    logic [7:0]        tx_byte_reg;
    logic              txd_reg;
    logic              ovr_reg;
    logic              busy;
    logic              tx_wr;
    logic              status_rd;

    assign tx_wr        = mmio_hit && (word_off == OFF_TX) && dat_we[0];
    assign status_rd    = mmio_rd && (word_off == OFF_STATUS);
    assign busy         = (state_reg != IDLE);
    assign bit_idx_next = bit_idx_reg + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            tx_byte_reg <= 8'h00;
            txd_reg     <= 1'b1;
            ovr_reg     <= 1'b0;
        end else begin
            // Overrun set takes priority over the read-to-clear.
            if (tx_wr && busy) begin
                ovr_reg <= 1'b1;
            end else if (status_rd) begin
                ovr_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (tx_wr) begin
                        tx_byte_reg <= dat_wd[7:0];
                        state_reg   <= START;
                        txd_reg     <= 1'b0;
                        baud_reg    <= BAUD_LAST;
                    end
                end
                START: begin
                    if (baud_reg == '0) begin
                        state_reg   <= DATA;
                        bit_idx_reg <= 3'd0;
                        txd_reg     <= tx_byte_reg[0];
                        baud_reg    <= BAUD_LAST;
                    end else begin
                        baud_reg <= baud_reg - BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_reg == '0) begin
                        baud_reg <= BAUD_LAST;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                            txd_reg   <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_next;
                            txd_reg     <= tx_byte_reg[bit_idx_next];
                        end
                    end else begin
                        baud_reg <= baud_reg - BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_reg == '0) begin
                        state_reg <= IDLE;
                        txd_reg   <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg - BAUD_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign status_word = {30'h0, ovr_reg, busy};
    assign uart_txd    = txd_reg;
`else
    assign status_word = 32'h0;
    assign uart_txd    = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    logic [31:0] mmio_rdata_next;
    logic [31:0] mmio_rdata_reg;
    logic        rd_mmio_reg;
    logic        post_rst_reg;

    // Sampled from current register state, so a same-cycle write is not visible.
    always_comb begin
        mmio_rdata_next = 32'h0;
        case (word_off)
            OFF_MTIME_LO: mmio_rdata_next = mtime_reg[31:0];
            OFF_MTIME_HI: mmio_rdata_next = mtime_reg[63:32];
            OFF_CMP_LO:   mmio_rdata_next = mtimecmp_reg[31:0];
            OFF_CMP_HI:   mmio_rdata_next = mtimecmp_reg[63:32];
            OFF_STATUS:   mmio_rdata_next = status_word;
            default:      mmio_rdata_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mmio_reg    <= 1'b0;
            mmio_rdata_reg <= 32'h0;
            post_rst_reg   <= 1'b1;
        end else begin
            rd_mmio_reg  <= mmio_rd;
            post_rst_reg <= 1'b0;
            if (mmio_rd) begin
                mmio_rdata_reg <= mmio_rdata_next;
            end
        end
    end

    // The SRAM output is meaningless right after reset, so mask it for that one cycle.
    assign dat_rd = rd_mmio_reg  ? mmio_rdata_reg :
                    post_rst_reg ? 32'h0          : ram_rd;

endmodule

// File: tb/tb_core_dbus.sv
// Scoreboard bench for core_dbus: SRAM passthrough, timer, UART frame, overrun and mid-frame reset.
module tb_core_dbus;

    localparam int          BAUD = 4;
    localparam logic [15:0] BASE = 16'hFF00;
`ifdef DBUS_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dat_a = 16'h0;
    logic [3:0]  dat_we = 4'h0;
    logic [31:0] dat_wd = 32'h0;
    logic [3:0]  dat_re = 4'h0;
    logic [31:0] dat_rd;
    logic [15:0] ram_a;
    logic [3:0]  ram_we;
    logic [31:0] ram_wd;
    logic [3:0]  ram_re;
    logic [31:0] ram_rd = 32'hBAD0_BAD0;
    logic        tmr_irq;
    logic        uart_txd;

    core_dbus #(.MMIO_BASE(BASE), .BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst),
        .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd),
        .ram_a(ram_a), .ram_we(ram_we), .ram_wd(ram_wd), .ram_re(ram_re), .ram_rd(ram_rd),
        .tmr_irq(tmr_irq), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    // Simple one-cycle-latency SRAM
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (|ram_re) ram_rd <= mem[ram_a[9:2]];
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_a[9:2]][b*8 +: 8] <= ram_wd[b*8 +: 8];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read scoreboard: expectation pushed at issue, popped when dat_rd is due.
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic        rd_issue   = 1'b0;
    logic        rd_issue_d = 1'b0;

    always @(posedge clk) rd_issue_d <= rd_issue;

    always @(negedge clk) begin
        string       t;
        logic [31:0] e;
        if (rd_issue_d) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                check(t, dat_rd, e);
            end
        end
    end

    logic [3:0]  last_ram_we;
    logic [3:0]  last_ram_re;
    logic [15:0] last_ram_a;
    logic [31:0] last_ram_wd;

    task automatic bus(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re, input string tag, input logic [31:0] exp);
        dat_a = a; dat_we = we; dat_wd = wd; dat_re = re;
        rd_issue = |re;
        if (|re) begin
            tag_q.push_back(tag);
            exp_q.push_back(exp);
        end
        if ((|we) || (|re))
            $display("txn %s a=%h we=%h wd=%h re=%h", tag, a, we, wd, re);
        #1;
        last_ram_we = ram_we; last_ram_re = ram_re; last_ram_a = ram_a; last_ram_wd = ram_wd;
        @(posedge clk); #1;
        dat_we = 4'h0; dat_re = 4'h0; rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd, input string tag);
        bus(a, we, wd, 4'h0, tag, 32'h0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
        bus(a, 4'h0, 32'h0, 4'hF, tag, exp);
    endtask

    task automatic idle();
        bus(16'h0000, 4'h0, 32'h0, 4'h0, "idle", 32'h0);
    endtask

    // mode 0: plain frame with status polling; 1: overrun; 2: reset during data bit 3
    task automatic uart_frame(input logic [7:0] b, input int mode);
        logic [9:0] fr;
        logic       exp_txd;
        fr = {1'b1, b, 1'b0};
        wr(BASE + 16'h10, 4'b0001, {24'h0, b}, "tx_start");
        for (int k = 1; k <= 44; k++) begin
            exp_txd = (!UART_EN || k > 10 * BAUD) ? 1'b1 : fr[(k - 1) / BAUD];
            check($sformatf("txd_m%0d_k%0d", mode, k), uart_txd, exp_txd);
            if (mode == 0 && k <= 41) begin
                rd(BASE + 16'h14, (UART_EN && k <= 40) ? 32'h1 : 32'h0, $sformatf("status_k%0d", k));
            end else if (mode == 1 && k == 1) begin
                wr(BASE + 16'h10, 4'b0001, {24'h0, ~b}, "tx_overrun");
            end else if (mode == 1 && k == 2) begin
                rd(BASE + 16'h14, UART_EN ? 32'h3 : 32'h0, "status_ovr");
            end else if (mode == 1 && k == 3) begin
                rd(BASE + 16'h14, UART_EN ? 32'h1 : 32'h0, "status_ovr_clr");
            end else if (mode == 1 && k == 41) begin
                rd(BASE + 16'h14, 32'h0, "status_ovr_done");
            end else if (mode == 2 && k == 2) begin
                wr(BASE + 16'h10, 4'b0001, 32'h55, "tx_overrun2");
            end else if (mode == 2 && k == 18) begin
                rst = 1'b1;
                idle();
                rst = 1'b0;
                check("midrst_txd", uart_txd, 1'b1);
                rd(BASE, 32'h0, "midrst_mtime");
                rd(BASE + 16'h14, 32'h0, "midrst_status");
                check("midrst_txd_hold", uart_txd, 1'b1);
                return;
            end else begin
                idle();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    int rise;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_dat_rd", dat_rd, 32'h0);
        check("rst_irq", tmr_irq, 1'b0);
        check("rst_txd", uart_txd, 1'b1);
        rd(BASE, 32'h0, "rst_mtime_lo");
        rd(BASE + 16'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(BASE + 16'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(BASE + 16'h14, 32'h0, "rst_status");

        // SRAM passthrough
        wr(16'h0100, 4'hF, 32'hDEAD_BEEF, "sram_st");
        check("sram_st_we", last_ram_we, 4'hF);
        check("sram_st_a", last_ram_a, 16'h0100);
        check("sram_st_wd", last_ram_wd, 32'hDEAD_BEEF);
        rd(16'h0100, 32'hDEAD_BEEF, "sram_ld");
        check("sram_ld_re", last_ram_re, 4'hF);
        wr(16'h0100, 4'b0010, 32'h0000_AA00, "sram_st_be");
        check("sram_st_be_we", last_ram_we, 4'b0010);
        rd(16'h0100, 32'hDEAD_AAEF, "sram_ld_be");

        // MMIO decode, byte enables, read-during-write, unmapped
        wr(BASE + 16'h08, 4'b0001, 32'h1234_5678, "cmp_lo_be");
        check("mmio_cmp_no_we", last_ram_we, 4'h0);
        rd(BASE + 16'h08, 32'hFFFF_FF78, "cmp_lo_be_rd");
        wr(BASE, 4'hF, 32'd100, "mtime_ld");
        check("mmio_ff00_we", last_ram_we, 4'h0);
        bus(BASE, 4'hF, 32'd7, 4'hF, "mtime_rw", 32'd100);
        check("mmio_ff00_rw_we", last_ram_we, 4'h0);
        check("mmio_ff00_rw_re", last_ram_re, 4'h0);
        rd(BASE, 32'd7, "mtime_after_rw");
        wr(BASE + 16'h40, 4'hF, 32'hCAFE_F00D, "unmapped_wr");
        rd(BASE + 16'h40, 32'h0, "unmapped_rd");
        rd(BASE + 16'h10, 32'h0, "txdata_rd");

        // mtime wrap
        wr(BASE + 16'h04, 4'hF, 32'hFFFF_FFFF, "mtime_hi_ld");
        wr(BASE, 4'hF, 32'hFFFF_FFFE, "mtime_lo_ld");
        rd(BASE, 32'hFFFF_FFFE, "wrap_lo_pre");
        rd(BASE + 16'h04, 32'hFFFF_FFFF, "wrap_hi_ones");
        rd(BASE + 16'h04, 32'h0, "wrap_hi_zero");
        rd(BASE, 32'h1, "wrap_lo_post");

        // Timer compare interrupt
        wr(BASE + 16'h08, 4'hF, 32'd50, "cmp_lo_50");
        wr(BASE + 16'h0C, 4'hF, 32'h0, "cmp_hi_0");
        wr(BASE, 4'hF, 32'h0, "mtime_zero");
        rise = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (tmr_irq === 1'b1 && rise == 0) rise = k;
        end
        check("irq_rise_cycles", rise, 51);
        wr(BASE + 16'h0C, 4'hF, 32'h1, "cmp_hi_up");
        check("irq_hold", tmr_irq, 1'b1);
        idle();
        check("irq_fall", tmr_irq, 1'b0);

        // UART
        uart_frame(8'hA5, 0);
        uart_frame(8'h3C, 1);
        uart_frame(8'hF0, 2);

        repeat (3) idle();
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
